// File: rtl/sect571r1_pt_mul_host.sv
// Host-side sequencer for a sect571r1 point multiplier: gathers a 571-bit scalar
// from 32-bit words, starts the multiplier, then streams the x/y result as 36 words.
module sect571r1_pt_mul_host #(
  parameter int NumWords = 18
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  output logic         mul_clr,
  output logic         mul_start,
  output logic [570:0] mul_d,
  input  logic         mul_done,
  input  logic [570:0] mul_x,
  input  logic [570:0] mul_y,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_data,
  output logic         out_last,
  output logic         busy
);

  localparam int OpW   = 571;
  localparam int InW   = $clog2(NumWords);
  localparam int OutW  = $clog2(2 * NumWords);
  localparam int LastW = OpW - 32 * (NumWords - 1);
  localparam logic [InW-1:0]  InLast  = InW'(NumWords - 1);
  localparam logic [OutW-1:0] OutLast = OutW'(2 * NumWords - 1);
  localparam logic [OutW-1:0] YBase   = OutW'(NumWords);

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_START,
    ST_WAIT,
    ST_CAPT,
    ST_SEND
  } state_t;

  state_t              state_q, state_d;
  logic [InW-1:0]      in_cnt_q, in_cnt_d;
  logic [OutW-1:0]     out_cnt_q, out_cnt_d;
  logic [OpW-1:0]      mul_d_q, mul_d_d;
  logic [OpW-1:0]      x_q, x_d;
  logic [OpW-1:0]      y_q, y_d;
  logic                mul_start_q, mul_start_d;
  logic                out_valid_q, out_valid_d;
  logic                mul_clr_q;
  logic                done_q;

  // The top word is only LastW bits wide; its unused upper bits read as zero.
  function automatic logic [31:0] word_of(input logic [OpW-1:0] v,
                                          input logic [OutW-1:0] idx);
    logic [31:0] w;
    w = '0;
    for (int k = 0; k < NumWords - 1; k++) begin
      if (idx == OutW'(k)) w = v[k*32 +: 32];
    end
    if (idx == OutW'(NumWords - 1)) w = {{(32-LastW){1'b0}}, v[OpW-1 -: LastW]};
    return w;
  endfunction

  logic            sel_y;
  logic [OutW-1:0] word_idx;

  assign sel_y    = (out_cnt_q >= YBase);
  assign word_idx = sel_y ? (out_cnt_q - YBase) : out_cnt_q;

  assign in_ready  = (state_q == ST_LOAD);
  assign busy      = (state_q != ST_LOAD);
  assign mul_d     = mul_d_q;
  assign mul_start = mul_start_q;
  assign mul_clr   = mul_clr_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_valid_q ? word_of(sel_y ? y_q : x_q, word_idx) : 32'h0;
  assign out_last  = out_valid_q && (out_cnt_q == OutLast);

  always_comb begin
    state_d     = state_q;
    in_cnt_d    = in_cnt_q;
    out_cnt_d   = out_cnt_q;
    mul_d_d     = mul_d_q;
    x_d         = x_q;
    y_d         = y_q;
    mul_start_d = 1'b0;
    out_valid_d = out_valid_q;

    case (state_q)
      ST_LOAD: begin
        if (in_valid) begin
          for (int k = 0; k < NumWords - 1; k++) begin
            if (in_cnt_q == InW'(k)) mul_d_d[k*32 +: 32] = in_data;
          end
          if (in_cnt_q == InLast) begin
            mul_d_d[OpW-1 -: LastW] = in_data[LastW-1:0];
            in_cnt_d    = '0;
            state_d     = ST_START;
            mul_start_d = 1'b1;
          end else begin
            in_cnt_d = in_cnt_q + InW'(1);
          end
        end
      end
      ST_START: state_d = ST_WAIT;
      ST_WAIT: begin
        // Only a fresh rising edge of done counts; a level held from earlier is ignored.
        if (mul_done && !done_q) state_d = ST_CAPT;
      end
      ST_CAPT: begin
        x_d         = mul_x;
        y_d         = mul_y;
        out_cnt_d   = '0;
        out_valid_d = 1'b1;
        state_d     = ST_SEND;
      end
      ST_SEND: begin
        if (out_ready) begin
          if (out_cnt_q == OutLast) begin
            out_cnt_d   = '0;
            out_valid_d = 1'b0;
            state_d     = ST_LOAD;
          end else begin
            out_cnt_d = out_cnt_q + OutW'(1);
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase

    // Clear wins over any handshake in the same cycle.
    if (clr) begin
      state_d     = ST_LOAD;
      in_cnt_d    = '0;
      out_cnt_d   = '0;
      mul_d_d     = '0;
      x_d         = '0;
      y_d         = '0;
      mul_start_d = 1'b0;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_LOAD;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      mul_d_q     <= '0;
      x_q         <= '0;
      y_q         <= '0;
      mul_start_q <= 1'b0;
      out_valid_q <= 1'b0;
      mul_clr_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_cnt_q    <= in_cnt_d;
      out_cnt_q   <= out_cnt_d;
      mul_d_q     <= mul_d_d;
      x_q         <= x_d;
      y_q         <= y_d;
      mul_start_q <= mul_start_d;
      out_valid_q <= out_valid_d;
      mul_clr_q   <= clr;
      done_q      <= mul_done;
    end
  end

endmodule

// File: tb/tb_sect571r1_pt_mul_host.sv
// Directed bench for sect571r1_pt_mul_host with a simple point-multiplier stand-in
// that raises done 50 cycles after each start pulse.
module tb_sect571r1_pt_mul_host;

  logic         clk;
  logic         rst_n;
  logic         clr;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic         mul_clr;
  logic         mul_start;
  logic [570:0] mul_d;
  logic         mul_done;
  logic [570:0] mul_x;
  logic [570:0] mul_y;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_data;
  logic         out_last;
  logic         busy;

  logic model_done;
  logic hold_done;
  int   checks;
  int   errors;

  sect571r1_pt_mul_host #(.NumWords(18)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .mul_clr   (mul_clr),
    .mul_start (mul_start),
    .mul_d     (mul_d),
    .mul_done  (mul_done),
    .mul_x     (mul_x),
    .mul_y     (mul_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mul_done = model_done | hold_done;

  // Multiplier stand-in: done pulses 50 cycles after a start pulse is seen.
  initial begin
    model_done = 1'b0;
    forever begin
      @(negedge clk);
      if (mul_start) begin
        repeat (50) @(negedge clk);
        model_done = 1'b1;
        @(negedge clk);
        model_done = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [575:0] obs, input logic [575:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] in_word(input logic [31:0] w0, input logic [31:0] mid,
                                          input logic [31:0] w17, input int k);
    logic [31:0] w;
    if (k == 0) w = w0;
    else if (k == 17) w = w17;
    else if (mid == 32'h0) w = 32'h0;
    else w = {mid[31:8], 8'(k)};
    return w;
  endfunction

  // scen 0: x=1, y=2.  scen 1: x and y all ones (top word has only 27 bits).
  function automatic logic [31:0] exp_word(input int scen, input int j);
    logic [31:0] w;
    w = 32'h0;
    if (scen == 0) begin
      if (j == 0) w = 32'h1;
      if (j == 18) w = 32'h2;
    end else begin
      if (j == 17 || j == 35) w = 32'h07FF_FFFF;
      else w = 32'hFFFF_FFFF;
    end
    return w;
  endfunction

  task automatic load(input logic [31:0] w0, input logic [31:0] mid, input logic [31:0] w17);
    logic [575:0] e;
    e = '0;
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      if (k == 0) chk("in_ready_load", in_ready, 1'b1);
      in_valid = 1'b1;
      in_data  = in_word(w0, mid, w17, k);
      e[k*32 +: 32] = in_data;
    end
    @(negedge clk);
    chk("mul_start_hi", mul_start, 1'b1);
    chk("busy_start", busy, 1'b1);
    chk("in_ready_start", in_ready, 1'b0);
    chk("mul_d", mul_d, {5'b0, e[570:0]});
    @(negedge clk);
    in_valid = 1'b0;
    chk("mul_start_lo", mul_start, 1'b0);
  endtask

  task automatic receive(input bit toggle, input int clr_at, input int scen);
    int got;
    int cyc;
    bit stalled;
    logic [31:0] held;
    got = 0;
    cyc = 0;
    stalled = 1'b0;
    held = 32'h0;
    while (got < 36 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (stalled) begin
        chk("stall_data", out_data, held);
        chk("stall_valid", out_valid, 1'b1);
        stalled = 1'b0;
      end
      if (out_valid && got == clr_at) begin
        clr = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        out_ready = 1'b0;
        chk("clr_valid", out_valid, 1'b0);
        chk("clr_in_ready", in_ready, 1'b1);
        chk("clr_busy", busy, 1'b0);
        chk("clr_mul_d", mul_d, '0);
        chk("mul_clr_hi", mul_clr, 1'b1);
        @(negedge clk);
        chk("mul_clr_lo", mul_clr, 1'b0);
        return;
      end
      out_ready = toggle ? cyc[0] : 1'b1;
      if (out_valid) begin
        if (out_ready) begin
          chk($sformatf("word%0d", got), out_data, exp_word(scen, got));
          chk($sformatf("last%0d", got), out_last, (got == 35));
          got++;
        end else begin
          stalled = 1'b1;
          held = out_data;
        end
      end
    end
    if (got < 36) chk("recv_timeout", got, 36);
    @(negedge clk);
    out_ready = 1'b0;
    chk("end_valid", out_valid, 1'b0);
    chk("end_in_ready", in_ready, 1'b1);
    chk("end_busy", busy, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_mul_d"}, mul_d, '0);
    chk({tag, "_mul_start"}, mul_start, 1'b0);
    chk({tag, "_mul_clr"}, mul_clr, 1'b0);
    chk({tag, "_out_valid"}, out_valid, 1'b0);
    chk({tag, "_out_data"}, out_data, 32'h0);
    chk({tag, "_out_last"}, out_last, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    int cyc;
    bit seen;
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    clr       = 1'b0;
    in_valid  = 1'b0;
    in_data   = 32'h0;
    out_ready = 1'b0;
    hold_done = 1'b0;
    mul_x     = 571'h1;
    mul_y     = 571'h2;

    #1;
    check_reset_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1'b1);

    // Basic operation, no back-pressure.
    load(32'h1, 32'h0, 32'h0);
    receive(1'b0, -1, 0);

    // Top scalar word truncated to 27 bits; all-ones result under back-pressure.
    mul_x = {571{1'b1}};
    mul_y = {571{1'b1}};
    load(32'h0, 32'h0, 32'hFFFF_FFFF);
    receive(1'b1, -1, 1);

    // Clear in the middle of SEND, then a full operation afterwards.
    mul_x = 571'h1;
    mul_y = 571'h2;
    load(32'hA5A5_0001, 32'h1234_5600, 32'hABCD_EF01);
    receive(1'b0, 10, 0);
    load(32'h1, 32'h0, 32'h0);
    receive(1'b1, -1, 0);

    // done held high from before start: no capture; then reset during WAIT.
    hold_done = 1'b1;
    load(32'h1, 32'h0, 32'h0);
    seen = 1'b0;
    for (cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("held_done_no_capture", seen, 1'b0);
    chk("held_done_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("wait_rst");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("wait_rst_in_ready", in_ready, 1'b1);
    seen = 1'b0;
    for (cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("wait_rst_no_output", seen, 1'b0);
    hold_done = 1'b0;

    // Reset in the middle of SEND abandons the transfer.
    load(32'h1, 32'h0, 32'h0);
    seen = 1'b0;
    for (cyc = 0; cyc < 200 && !seen; cyc++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("send_rst_reached", seen, 1'b1);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("send_rst");
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    out_ready = 1'b0;
    chk("send_rst_no_words", seen, 1'b0);
    chk("send_rst_in_ready", in_ready, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
